// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal NIC array: register map, status bit
// positions and drop-counter width.
package cardinal_nic_pkg;

    // Per-node register window (2-bit address)
    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    // Status word layout
    localparam int STAT_IN_NEMPTY_BIT = 0;
    localparam int STAT_OUT_FULL_BIT  = 0;
    localparam int STAT_DROP_LSB      = 8;

    // Dropped-write counter (only present with CARDINAL_NIC_DROP_CNT_EN)
    localparam int               DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/cardinal_nic_fifo.sv
// Single-clock DEPTH-entry FIFO used for both directions of a NIC channel.
// Push is ignored when full and pop is ignored when empty; both are judged
// on the occupancy registered at the start of the cycle, so a push and a pop
// in the same cycle are both honoured only when neither limit applies.
module cardinal_nic_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
        end
    end

    // Storage is data only; contents are meaningless until counted in
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cardinal_nic_array.sv
// Array of N_NODES processor<->ring NIC channels, each with an input FIFO
// (router to processor) and an output FIFO (processor to router) behind a
// 2-bit memory-mapped register window.
// Optional feature: define CARDINAL_NIC_DROP_CNT_EN to add a per-node 8-bit
// saturating count of dropped output writes, read on status 11 bits 15:8 and
// cleared by any write to 11.
module cardinal_nic_array
    import cardinal_nic_pkg::*;
#(
    parameter int N_NODES = 4,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [2*N_NODES-1:0]      nic_addr,
    input  logic [DATA_W*N_NODES-1:0] nic_din,
    output logic [DATA_W*N_NODES-1:0] nic_dout,
    input  logic [N_NODES-1:0]        nic_en,
    input  logic [N_NODES-1:0]        nic_wr_en,
    input  logic [N_NODES-1:0]        net_si_valid,
    output logic [N_NODES-1:0]        net_si_ready,
    input  logic [DATA_W*N_NODES-1:0] net_si_data,
    output logic [N_NODES-1:0]        net_so_valid,
    input  logic [N_NODES-1:0]        net_so_ready,
    output logic [DATA_W*N_NODES-1:0] net_so_data
);

    for (genvar k = 0; k < N_NODES; k++) begin : g_node
        logic [1:0]            addr;
        logic                  rd_req;
        logic                  wr_req;
        logic                  in_full;
        logic                  in_empty;
        logic                  in_pop;
        logic [DATA_W-1:0]     in_head;
        logic                  out_full;
        logic                  out_empty;
        logic                  out_push;
        logic [DATA_W-1:0]     out_head;
        logic [DATA_W-1:0]     rd_data;
        logic [DATA_W-1:0]     dout_p1;
        logic [DROP_CNT_W-1:0] drop_cnt;

        assign addr   = nic_addr[k*2 +: 2];
        assign rd_req = nic_en[k] && !nic_wr_en[k];
        assign wr_req = nic_en[k] && nic_wr_en[k];

        // A read of the input data register pops only when there is data
        assign in_pop   = rd_req && (addr == ADDR_IN_DATA) && !in_empty;
        assign out_push = wr_req && (addr == ADDR_OUT_DATA);

        cardinal_nic_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_in_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (net_si_valid[k]),
            .pop   (in_pop),
            .din   (net_si_data[k*DATA_W +: DATA_W]),
            .head  (in_head),
            .full  (in_full),
            .empty (in_empty)
        );

        cardinal_nic_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_out_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (out_push),
            .pop   (net_so_ready[k]),
            .din   (nic_din[k*DATA_W +: DATA_W]),
            .head  (out_head),
            .full  (out_full),
            .empty (out_empty)
        );

        assign net_si_ready[k]                 = !in_full;
        assign net_so_valid[k]                 = !out_empty;
        assign net_so_data[k*DATA_W +: DATA_W] = out_head;

`ifdef CARDINAL_NIC_DROP_CNT_EN
        logic drop;
        logic clear;

        // A write to a full output FIFO is lost even if the router pops now
        assign drop  = out_push && out_full;
        assign clear = wr_req && (addr == ADDR_OUT_STAT);

        // Saturating drop count; a clear coinciding with a drop leaves 1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                drop_cnt <= '0;
            end else if (clear) begin
                drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
            end else if (drop && (drop_cnt != DROP_CNT_MAX)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
`else
        assign drop_cnt = '0;
`endif

        // Register read mux; unused status bits read 0
        always_comb begin
            rd_data = '0;
            case (addr)
                ADDR_IN_DATA:  if (!in_empty) rd_data = in_head;
                ADDR_IN_STAT:  rd_data[STAT_IN_NEMPTY_BIT] = !in_empty;
                ADDR_OUT_DATA: rd_data = '0;
                ADDR_OUT_STAT: begin
                    rd_data[STAT_OUT_FULL_BIT]                  = out_full;
                    rd_data[STAT_DROP_LSB +: DROP_CNT_W]        = drop_cnt;
                end
                default:       rd_data = '0;
            endcase
        end

        // Stage p1: registered read data, held until the next read
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                dout_p1 <= '0;
            end else if (rd_req) begin
                dout_p1 <= rd_data;
            end
        end

        assign nic_dout[k*DATA_W +: DATA_W] = dout_p1;
    end

endmodule
